axi_master_burst_engine: RTL
============================

# axi_master_burst_engine

Synthesizable AXI-style initiator that converts single read or write commands from a local command port into one burst on the lab AXI bus. It is the requesting end of the slave/responder models and peripherals on the same bus: it issues address, write-data and response handshakes and receives read beats, one transaction at a time. It sits between lab control logic (JTAG/UDP command decoders) and the AXI interconnect.

## Interface
- BURST, 2'b01, value driven on WR/RD_ADDR_BURST (INCR)
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with AXI_MASTER_TIMEOUT_EN)
- clk  in  1  clock; all logic on posedge
- rstn  in  1  reset, synchronous, active-low
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  32  start address; cmd_len  in  8  beats−1; cmd_id  in  4  transaction ID
- wr_data_i  in  32; wr_valid_i  in  1; wr_ready_o  out  1  write-data source stream
- rd_data_o  out  32; rd_last_o  out  1; rd_valid_o  out  1; rd_ready_i  in  1  read-data sink stream
- done_valid  out  1  one-cycle completion pulse; done_resp  out  2; done_id  out  4
- MASTER_WR_ADDR_ID/ADDR/LEN/BURST/VALID  out  4/32/8/2/1; MASTER_WR_ADDR_READY  in  1
- MASTER_WR_DATA/STRB/LAST/VALID  out  32/4/1/1; MASTER_WR_DATA_READY  in  1
- MASTER_WR_BACK_ID/RESP/VALID  in  4/2/1; MASTER_WR_BACK_READY  out  1
- MASTER_RD_ADDR_ID/ADDR/LEN/BURST/VALID  out  4/32/8/2/1; MASTER_RD_ADDR_READY  in  1
- MASTER_RD_BACK_ID/DATA/DATA_RESP/DATA_LAST/DATA_VALID  in  4/32/2/1/1; MASTER_RD_DATA_READY  out  1

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: cmd_ready=1; on cmd_valid latch addr/len/id, clear beat counter and resp accumulator; go to WR_ADDR or RD_ADDR.
- WR_ADDR/RD_ADDR: ADDR_VALID=1 with latched fields, held stable until ADDR_READY; on handshake go to WR_DATA/RD_DATA.
- WR_DATA: MASTER_WR_DATA_VALID=wr_valid_i, wr_ready_o=MASTER_WR_DATA_READY (combinational gating, both 0 outside this state); STRB=4'hF; LAST=1 when beat counter == len. After last handshake go to WR_RESP.
- WR_RESP: WR_BACK_READY=1; on handshake resp=WR_BACK_RESP, ID mismatch forces 2'b10; go DONE.
- RD_DATA: rd_valid_o=MASTER_RD_DATA_VALID, MASTER_RD_DATA_READY=rd_ready_i; resp accumulator = max(accumulated, DATA_RESP). Ends on handshake with DATA_LAST. LAST before beat len, or no LAST at beat len (continue until LAST), or ID mismatch → resp forced 2'b10; go DONE.
- DONE: done_valid=1 for one cycle with done_resp/done_id; return to IDLE.
- Beat counter 9 bits, saturating at 256; no address arithmetic (slave increments).
- cmd_valid in non-IDLE states is ignored (cmd_ready=0).

## Timing
- Reset values: all VALID/READY outputs 0, cmd_ready 0 during reset then 1 in IDLE, addr/len/id/data outputs 0, BURST=BURST, STRB=4'hF, done_* 0.
- Command accept → ADDR_VALID next cycle. Minimum write of 1 beat: accept, AW, W, B, DONE = 5 cycles with zero-wait slave.
- Back-to-back: next command accepted the cycle after DONE.
- rstn low mid-burst: FSM to IDLE next edge, all VALIDs drop, no done pulse.
- B response arriving before WR_DATA completes is not accepted (BREADY=0) until WR_RESP.

## Configuration
- AXI_MASTER_TIMEOUT_EN defined: counter clears on any handshake or state change; reaching TIMEOUT_CYC in any non-IDLE/DONE state drops all VALID/READY, issues DONE with done_resp=2'b11.
- Undefined: no counter; FSM waits indefinitely.

## Structure
- Package axi_master_pkg: state enum, RESP_OKAY/EXOKAY/SLVERR/DECERR constants, BURST_INCR constant.
- One sub-module axi_master_watchdog (counter + compare), instantiated only under AXI_MASTER_TIMEOUT_EN.

## Test plan
- Write addr 0x10, len 3, id 5, data 0xA0..0xA3, slave READY every 4th cycle → 4 beats, LAST on 4th only, done_resp 00, done_id 5; slave memory 0x10..0x13 holds data.
- Read back same → rd_data_o 0xA0..0xA3 in order, rd_last_o on 4th, done_resp 00.
- Read len 0 with rd_ready_i toggling → single beat, LAST on it, stall honoured, data stable while VALID&&!READY.
- Slave returns LAST at beat 2 of len 3 read → done at that beat, done_resp 10.
- rstn low during WR_DATA beat 2 → all VALIDs 0 after next edge, no done_valid, next command accepted normally.
- AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYC 16, slave never asserts WR_ADDR_READY → done_valid at cycle 17 after AW start, done_resp 11.

Source files
------------

// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI burst master: FSM state encoding,
// response codes and the INCR burst type.
package axi_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_master_watchdog.sv
// Stall watchdog for the AXI burst master: counts idle cycles while a
// transaction is active and flags expiry when TIMEOUT_CYC is reached.
module axi_master_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_active,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn || !i_active || i_clear) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_active && (r_cnt == CW'(TIMEOUT_CYC));

endmodule

// File: rtl/axi_master_burst_engine.sv
// Single-transaction AXI burst master: one local command becomes one INCR burst.
// Optional stall watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_master_burst_engine
    import axi_master_pkg::*;
#(
    parameter logic [1:0]  BURST       = BURST_INCR,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [3:0]  cmd_id,

    input  logic [31:0] wr_data_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,

    output logic [31:0] rd_data_o,
    output logic        rd_last_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,

    output logic        done_valid,
    output logic [1:0]  done_resp,
    output logic [3:0]  done_id,

    output logic [3:0]  MASTER_WR_ADDR_ID,
    output logic [31:0] MASTER_WR_ADDR_ADDR,
    output logic [7:0]  MASTER_WR_ADDR_LEN,
    output logic [1:0]  MASTER_WR_ADDR_BURST,
    output logic        MASTER_WR_ADDR_VALID,
    input  logic        MASTER_WR_ADDR_READY,

    output logic [31:0] MASTER_WR_DATA,
    output logic [3:0]  MASTER_WR_DATA_STRB,
    output logic        MASTER_WR_DATA_LAST,
    output logic        MASTER_WR_DATA_VALID,
    input  logic        MASTER_WR_DATA_READY,

    input  logic [3:0]  MASTER_WR_BACK_ID,
    input  logic [1:0]  MASTER_WR_BACK_RESP,
    input  logic        MASTER_WR_BACK_VALID,
    output logic        MASTER_WR_BACK_READY,

    output logic [3:0]  MASTER_RD_ADDR_ID,
    output logic [31:0] MASTER_RD_ADDR_ADDR,
    output logic [7:0]  MASTER_RD_ADDR_LEN,
    output logic [1:0]  MASTER_RD_ADDR_BURST,
    output logic        MASTER_RD_ADDR_VALID,
    input  logic        MASTER_RD_ADDR_READY,

    input  logic [3:0]  MASTER_RD_BACK_ID,
    input  logic [31:0] MASTER_RD_BACK_DATA,
    input  logic [1:0]  MASTER_RD_BACK_DATA_RESP,
    input  logic        MASTER_RD_BACK_DATA_LAST,
    input  logic        MASTER_RD_BACK_DATA_VALID,
    output logic        MASTER_RD_DATA_READY
);

    state_t      r_state, w_next;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [3:0]  r_id;
    logic [8:0]  r_beat;
    logic [1:0]  r_resp;
    logic        r_err;

    logic w_timeout, w_at_len, w_in_wdata, w_in_rdata;
    logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rd_err;

    assign w_at_len   = (r_beat == {1'b0, r_len});
    assign w_in_wdata = (r_state == S_WR_DATA) && !w_timeout;
    assign w_in_rdata = (r_state == S_RD_DATA) && !w_timeout;

    // Command side and address channels; fields are held in registers so they stay stable
    assign cmd_ready            = rstn && (r_state == S_IDLE);
    assign MASTER_WR_ADDR_VALID = (r_state == S_WR_ADDR) && !w_timeout;
    assign MASTER_RD_ADDR_VALID = (r_state == S_RD_ADDR) && !w_timeout;
    assign MASTER_WR_ADDR_ID    = r_id;
    assign MASTER_WR_ADDR_ADDR  = r_addr;
    assign MASTER_WR_ADDR_LEN   = r_len;
    assign MASTER_WR_ADDR_BURST = BURST;
    assign MASTER_RD_ADDR_ID    = r_id;
    assign MASTER_RD_ADDR_ADDR  = r_addr;
    assign MASTER_RD_ADDR_LEN   = r_len;
    assign MASTER_RD_ADDR_BURST = BURST;

    assign MASTER_WR_DATA_VALID = w_in_wdata && wr_valid_i;
    assign wr_ready_o           = w_in_wdata && MASTER_WR_DATA_READY;
    assign MASTER_WR_DATA       = w_in_wdata ? wr_data_i : '0;
    assign MASTER_WR_DATA_STRB  = '1;
    assign MASTER_WR_DATA_LAST  = w_in_wdata && w_at_len;
    assign MASTER_WR_BACK_READY = (r_state == S_WR_RESP) && !w_timeout;

    assign rd_valid_o           = w_in_rdata && MASTER_RD_BACK_DATA_VALID;
    assign MASTER_RD_DATA_READY = w_in_rdata && rd_ready_i;
    assign rd_data_o            = w_in_rdata ? MASTER_RD_BACK_DATA : '0;
    assign rd_last_o            = w_in_rdata && MASTER_RD_BACK_DATA_LAST;

    assign done_valid = (r_state == S_DONE);
    assign done_resp  = done_valid ? (r_err ? RESP_SLVERR : r_resp) : '0;
    assign done_id    = done_valid ? r_id : '0;

    assign w_cmd_hs = cmd_valid && cmd_ready;
    assign w_aw_hs  = MASTER_WR_ADDR_VALID && MASTER_WR_ADDR_READY;
    assign w_w_hs   = MASTER_WR_DATA_VALID && MASTER_WR_DATA_READY;
    assign w_b_hs   = MASTER_WR_BACK_READY && MASTER_WR_BACK_VALID;
    assign w_ar_hs  = MASTER_RD_ADDR_VALID && MASTER_RD_ADDR_READY;
    assign w_r_hs   = MASTER_RD_DATA_READY && MASTER_RD_BACK_DATA_VALID;

    // LAST must coincide with beat len: early LAST and missing LAST both mismatch here
    assign w_rd_err = (MASTER_RD_BACK_ID != r_id) || (MASTER_RD_BACK_DATA_LAST != w_at_len);

`ifdef AXI_MASTER_TIMEOUT_EN
    logic w_wd_active, w_wd_clear;

    assign w_wd_active = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_wd_clear  = (w_next != r_state) || w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;

    axi_master_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rstn      (rstn),
        .i_active  (w_wd_active),
        .i_clear   (w_wd_clear),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_cmd_hs) w_next = cmd_wr ? S_WR_ADDR : S_RD_ADDR;
            S_WR_ADDR: if (w_aw_hs) w_next = S_WR_DATA;
            S_WR_DATA: if (w_w_hs && w_at_len) w_next = S_WR_RESP;
            S_WR_RESP: if (w_b_hs) w_next = S_DONE;
            S_RD_ADDR: if (w_ar_hs) w_next = S_RD_DATA;
            S_RD_DATA: if (w_r_hs && MASTER_RD_BACK_DATA_LAST) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr <= '0;
            r_len  <= '0;
            r_id   <= '0;
            r_beat <= '0;
            r_resp <= RESP_OKAY;
            r_err  <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_addr <= cmd_addr;
                r_len  <= cmd_len;
                r_id   <= cmd_id;
                r_beat <= '0;
                r_resp <= RESP_OKAY;
                r_err  <= 1'b0;
            end
            if ((w_w_hs || w_r_hs) && !r_beat[8]) begin
                r_beat <= r_beat + 9'd1;
            end
            if (w_b_hs) begin
                r_resp <= MASTER_WR_BACK_RESP;
                r_err  <= (MASTER_WR_BACK_ID != r_id);
            end
            if (w_r_hs) begin
                r_resp <= resp_max(r_resp, MASTER_RD_BACK_DATA_RESP);
                r_err  <= r_err || w_rd_err;
            end
            if (w_timeout) begin
                r_resp <= RESP_DECERR;
                r_err  <= 1'b0;
            end
        end
    end

endmodule
